// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported byte-lane data RAM.
// Optional statistics counters are compiled in with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [1:0]    a_mode,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic          a_err,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [1:0]    b_mode,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic          b_err,
   output logic [DW-1:0] b_rdata,
   output logic          ram_we,
   output logic [1:0]    ram_mode,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          busy
`ifdef MEM_ARB_STATS_EN
   ,
   input  logic          stat_clr,
   output logic [15:0]   stat_a_cnt,
   output logic [15:0]   stat_b_cnt,
   output logic [15:0]   stat_err_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t        state_q, state_d;
   logic          sel_q, sel_d;            // 0 = A, 1 = B
   logic          last_grant_q, last_grant_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic          ram_we_q, ram_we_d;
   logic [1:0]    ram_mode_q, ram_mode_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          a_ack_q, a_ack_d, a_err_q, a_err_d;
   logic          b_ack_q, b_ack_d, b_err_q, b_err_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic          grant_b, req_we, req_err;
   logic [1:0]    req_mode;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata, cap_rdata;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   stat_a_q, stat_a_d, stat_b_q, stat_b_d, stat_e_q, stat_e_d;
`endif

   function automatic logic align_err(input logic [1:0] mode, input logic [1:0] lo);
      case (mode)
         2'd0:    return lo != 2'b00;
         2'd1:    return lo[0];
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      err_d        = err_q;
      ram_we_d     = 1'b0;
      ram_mode_d   = ram_mode_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      a_ack_d      = 1'b0;
      a_err_d      = 1'b0;
      a_rdata_d    = a_rdata_q;
      b_ack_d      = 1'b0;
      b_err_d      = 1'b0;
      b_rdata_d    = b_rdata_q;
      // B wins only when A is idle or A had the previous grant
      grant_b      = b_req && (!a_req || !last_grant_q);
      req_we       = grant_b ? b_we    : a_we;
      req_mode     = grant_b ? b_mode  : a_mode;
      req_addr     = grant_b ? b_addr  : a_addr;
      req_wdata    = grant_b ? b_wdata : a_wdata;
      req_err      = align_err(req_mode, req_addr[1:0]);
      cap_rdata    = (err_q || we_q) ? '0 : ram_rdata;

      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               sel_d        = grant_b;
               last_grant_d = grant_b;
               we_d         = req_we;
               err_d        = req_err;
               ram_we_d     = req_we && !req_err;
               ram_mode_d   = req_mode;
               ram_addr_d   = req_addr;
               ram_wdata_d  = req_wdata;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (sel_q) begin
               b_ack_d   = 1'b1;
               b_err_d   = err_q;
               b_rdata_d = cap_rdata;
            end else begin
               a_ack_d   = 1'b1;
               a_err_d   = err_q;
               a_rdata_d = cap_rdata;
            end
            state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef MEM_ARB_STATS_EN
      stat_a_d = stat_a_q;
      stat_b_d = stat_b_q;
      stat_e_d = stat_e_q;
      if (stat_clr) begin
         stat_a_d = '0;
         stat_b_d = '0;
         stat_e_d = '0;
      end else if (state_q == S_RESP) begin
         if (!sel_q && stat_a_q != 16'hFFFF) stat_a_d = stat_a_q + 16'd1;
         if (sel_q && stat_b_q != 16'hFFFF)  stat_b_d = stat_b_q + 16'd1;
         if (err_q && stat_e_q != 16'hFFFF)  stat_e_d = stat_e_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_mode_q   <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         a_ack_q      <= 1'b0;
         a_err_q      <= 1'b0;
         a_rdata_q    <= '0;
         b_ack_q      <= 1'b0;
         b_err_q      <= 1'b0;
         b_rdata_q    <= '0;
`ifdef MEM_ARB_STATS_EN
         stat_a_q     <= '0;
         stat_b_q     <= '0;
         stat_e_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         err_q        <= err_d;
         ram_we_q     <= ram_we_d;
         ram_mode_q   <= ram_mode_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         a_ack_q      <= a_ack_d;
         a_err_q      <= a_err_d;
         a_rdata_q    <= a_rdata_d;
         b_ack_q      <= b_ack_d;
         b_err_q      <= b_err_d;
         b_rdata_q    <= b_rdata_d;
`ifdef MEM_ARB_STATS_EN
         stat_a_q     <= stat_a_d;
         stat_b_q     <= stat_b_d;
         stat_e_q     <= stat_e_d;
`endif
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_mode  = ram_mode_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign a_ack     = a_ack_q;
   assign a_err     = a_err_q;
   assign a_rdata   = a_rdata_q;
   assign b_ack     = b_ack_q;
   assign b_err     = b_err_q;
   assign b_rdata   = b_rdata_q;
   assign busy      = (state_q != S_IDLE);
`ifdef MEM_ARB_STATS_EN
   assign stat_a_cnt   = stat_a_q;
   assign stat_b_cnt   = stat_b_q;
   assign stat_err_cnt = stat_e_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-lane RAM.
// Stats checks are included when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [1:0]  a_mode, b_mode;
   logic [11:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        ram_we;
   logic [1:0]  ram_mode;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        busy;
`ifdef MEM_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_a_cnt, stat_b_cnt, stat_err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(12), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_mode(a_mode), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_mode(b_mode), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .ram_we(ram_we), .ram_mode(ram_mode), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
      , .stat_clr(stat_clr), .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt),
      .stat_err_cnt(stat_err_cnt)
`endif
   );

   // Byte-lane RAM: synchronous write, combinational zero-extended read
   logic [7:0] mem [4096];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata[7:0];
         if (ram_mode != 2'd2) mem[ram_addr + 12'd1] <= ram_wdata[15:8];
         if (ram_mode == 2'd0) begin
            mem[ram_addr + 12'd2] <= ram_wdata[23:16];
            mem[ram_addr + 12'd3] <= ram_wdata[31:24];
         end
      end
   end
   always_comb begin
      ram_rdata = '0;
      case (ram_mode)
         2'd0: ram_rdata = {mem[ram_addr + 12'd3], mem[ram_addr + 12'd2],
                            mem[ram_addr + 12'd1], mem[ram_addr]};
         2'd1: ram_rdata = {16'h0, mem[ram_addr + 12'd1], mem[ram_addr]};
         2'd2: ram_rdata = {24'h0, mem[ram_addr]};
         default: ram_rdata = '0;
      endcase
   end

   typedef struct {
      logic        port;     // 0 = A, 1 = B
      logic        we;
      logic [1:0]  mode;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic p, input logic w, input logic [1:0] m,
                               input logic [11:0] ad, input logic [31:0] wd,
                               input logic e, input logic [31:0] rd);
      vec_t v;
      v.port = p; v.we = w; v.mode = m; v.addr = ad; v.wdata = wd;
      v.exp_err = e; v.exp_rdata = rd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      if (!v.port) begin
         a_req = 1'b1; a_we = v.we; a_mode = v.mode; a_addr = v.addr; a_wdata = v.wdata;
      end else begin
         b_req = 1'b1; b_we = v.we; b_mode = v.mode; b_addr = v.addr; b_wdata = v.wdata;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction: ack 2 cycles after the sampling edge, exactly the expected write pulses
   task automatic run_txn(input vec_t v, input string nm);
      int cyc, wecnt;
      logic got, gerr, oack, rd_hold;
      logic [31:0] grd;
      cyc = 0; wecnt = 0; got = 0; gerr = 0; oack = 0; grd = '0; rd_hold = 0;
      @(negedge clk);
      drive(v);
      while (!got && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
         if (ram_we) wecnt++;
         got  = v.port ? b_ack : a_ack;
         gerr = v.port ? b_err : a_err;
         grd  = v.port ? b_rdata : a_rdata;
         oack = v.port ? a_ack : b_ack;
      end
      @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;
      chk({nm, " ack"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(cyc), 32'd2);
      chk({nm, " err"}, 32'(gerr), 32'(v.exp_err));
      chk({nm, " rdata"}, grd, v.exp_rdata);
      chk({nm, " we_pulses"}, 32'(wecnt), 32'(v.we && !v.exp_err));
      chk({nm, " other_ack"}, 32'(oack), 32'd0);
      @(posedge clk); #1;
      rd_hold = ((v.port ? b_rdata : a_rdata) === v.exp_rdata);
      chk({nm, " idle_after"}, {29'd0, busy, a_ack, b_ack}, 32'd0);
      chk({nm, " rdata_hold"}, 32'(rd_hold), 32'd1);
   endtask

   initial begin
      logic [11:0] ahist, bhist;
      logic        seen;
      int          cyc;
      rst_n = 1'b0;
      a_req = 0; a_we = 0; a_mode = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_mode = 0; b_addr = 0; b_wdata = 0;
`ifdef MEM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      vecs[0]  = mk(0, 1, 2'd0, 12'h010, 32'hDEADBEEF, 0, 32'h0);
      vecs[1]  = mk(0, 0, 2'd0, 12'h010, 32'h0,        0, 32'hDEADBEEF);
      vecs[2]  = mk(1, 1, 2'd2, 12'h013, 32'h0000005A, 0, 32'h0);
      vecs[3]  = mk(1, 0, 2'd0, 12'h010, 32'h0,        0, 32'h5AADBEEF);
      vecs[4]  = mk(0, 0, 2'd0, 12'h012, 32'h0,        1, 32'h0);
      vecs[5]  = mk(0, 1, 2'd1, 12'h011, 32'h00001111, 1, 32'h0);
      vecs[6]  = mk(0, 0, 2'd3, 12'h020, 32'h0,        1, 32'h0);
      vecs[7]  = mk(0, 0, 2'd0, 12'h010, 32'h0,        0, 32'h5AADBEEF);
      vecs[8]  = mk(1, 0, 2'd1, 12'h012, 32'h0,        0, 32'h00005AAD);
      vecs[9]  = mk(1, 0, 2'd2, 12'h013, 32'h0,        0, 32'h0000005A);
      vecs[10] = mk(0, 1, 2'd0, 12'h020, 32'hFFFFFFFF, 0, 32'h0);
      vecs[11] = mk(1, 1, 2'd1, 12'h020, 32'hAAAA1234, 0, 32'h0);
      vecs[12] = mk(0, 0, 2'd0, 12'h020, 32'h0,        0, 32'hFFFF1234);
      vecs[13] = mk(1, 0, 2'd0, 12'h012, 32'h0,        1, 32'h0);
      vecs[14] = mk(1, 1, 2'd3, 12'h010, 32'h0,        1, 32'h0);
      vecs[15] = mk(1, 0, 2'd0, 12'h010, 32'h0,        0, 32'h5AADBEEF);

      do_reset();
      #1;
      chk("reset ctl", {28'd0, busy, ram_we, ram_mode}, 32'd0);
      chk("reset addr", {20'd0, ram_addr}, 32'd0);
      chk("reset wdata", ram_wdata, 32'd0);
      chk("reset acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
      chk("reset a_rdata", a_rdata, 32'd0);
      chk("reset b_rdata", b_rdata, 32'd0);

      for (int i = 0; i < 16; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Both ports held after reset: A first, then strict alternation
      do_reset();
      drive(vecs[7]);
      drive(vecs[15]);
      ahist = '0; bhist = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         ahist[i] = a_ack;
         bhist[i] = b_ack;
      end
      @(negedge clk);
      a_req = 0; b_req = 0;
      chk("rr a_ack pattern", {20'd0, ahist}, 32'h082);
      chk("rr b_ack pattern", {20'd0, bhist}, 32'h410);
      chk("rr overlap", {20'd0, ahist & bhist}, 32'd0);
      chk("rr a_rdata", a_rdata, 32'h5AADBEEF);
      chk("rr b_rdata", b_rdata, 32'h5AADBEEF);
      @(posedge clk); #1;
      chk("rr idle", 32'(busy), 32'd0);

      // Req pulse that never sees an IDLE edge starts nothing
      a_addr = 12'h010; a_mode = 2'd0; a_we = 1'b0;
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (busy || a_ack) seen = 1;
      end
      chk("no grant on short req", 32'(seen), 32'd0);

      // Req dropped after grant still completes
      @(negedge clk);
      drive(vecs[7]);
      @(posedge clk); #1;
      chk("drop busy", 32'(busy), 32'd1);
      @(negedge clk);
      a_req = 1'b0;
      seen = 0; cyc = 0;
      while (!seen && cyc < 6) begin
         @(posedge clk); #1;
         cyc++;
         if (a_ack) seen = 1;
      end
      chk("drop ack", 32'(seen), 32'd1);
      chk("drop rdata", a_rdata, 32'h5AADBEEF);
      @(posedge clk); #1;

      // Reset during ACCESS of a B write
      @(negedge clk);
      drive(mk(1, 1, 2'd0, 12'h040, 32'hCAFEF00D, 0, 32'h0));
      @(posedge clk); #1;
      chk("mid ram_we in access", 32'(ram_we), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid after reset", {29'd0, busy, ram_we, b_ack}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; b_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (b_ack || ram_we || busy) seen = 1;
      end
      chk("mid no late ack/we", 32'(seen), 32'd0);
      run_txn(vecs[7], "post_reset");

`ifdef MEM_ARB_STATS_EN
      @(negedge clk);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("stat clr0", {stat_a_cnt, stat_b_cnt} | 32'(stat_err_cnt), 32'd0);
      for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("stat%0d", i));
      chk("stat a", 32'(stat_a_cnt), 32'd3);
      chk("stat b", 32'(stat_b_cnt), 32'd2);
      chk("stat err", 32'(stat_err_cnt), 32'd1);
      @(negedge clk);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("stat clr1", {stat_a_cnt, stat_b_cnt} | 32'(stat_err_cnt), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported byte-lane data RAM between two requesters: port A (CPU load/store stage) and port B (debug/DMA loader).
- Round-robin arbitration; each granted request is latched and one RAM access is sequenced; a one-cycle ack is returned with read data or an error flag.
- Sits between the requesters and the RAM's we/mode/ram_addr/data_in/data_out pins.
- RAM write is synchronous; RAM read is combinational. Mode encoding: 0 = word, 1 = halfword, 2 = byte, 3 = illegal.

Parameters:
- AW, 12, RAM byte-address width; must match the RAM address port.
- DW, 32, data width; fixed at 32. Other values are unsupported.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- a_req  in  1  port A request; held high with fields stable until a_ack.
- a_we  in  1  port A write enable (1 = store).
- a_mode  in  2  port A access size (0 = word, 1 = half, 2 = byte).
- a_addr  in  AW  port A byte address.
- a_wdata  in  32  port A store data, LSB-aligned as the RAM expects.
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  valid with a_ack; access rejected.
- a_rdata  out  32  load data, valid with a_ack.
- b_req, b_we, b_mode, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- ram_we  out  1  RAM write strobe.
- ram_mode  out  2  RAM mode.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  32  RAM data_in.
- ram_rdata  in  32  RAM data_out (combinational).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state = IDLE; ram_we = 0; ram_mode, ram_addr, ram_wdata = 0; all ack/err/rdata = 0; busy = 0; last_grant = B, so A wins the first tie.
- FSM state IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the port that is not last_grant.
  - On grant: latch we/mode/addr/wdata, set sel, update last_grant, compute err, go to ACCESS.
- err is set when any of these hold:
  - mode == 3;
  - mode == 0 and addr[1:0] != 0;
  - mode == 1 and addr[0] != 0.
- FSM state ACCESS (exactly one cycle):
  - ram_mode, ram_addr, ram_wdata are driven from the latched registers; they hold their values in all other states.
  - ram_we = latched_we & ~err. It is high only in ACCESS, so at most one write pulse per transaction.
  - ram_rdata is captured at the end of ACCESS; 0 is captured if err or latched_we.
  - Next state: RESP.
- FSM state RESP (exactly one cycle):
  - Selected port's ack = 1, err = latched err, rdata = captured value.
  - Other port's ack = 0.
  - Next state: IDLE.
- Outside RESP, ack and err are 0 and rdata holds its last value.
- Latency: req sampled in IDLE at cycle t gives ram_we at t+1 and ack at t+2. Minimum 3 cycles per transaction.
- Requester contract: drop req (or present a new request) in the cycle after ack. Requests are never sampled in ACCESS or RESP.
- Starvation bound: with both ports requesting continuously, grants strictly alternate. Each port waits at most one foreign transaction (3 cycles).
- Request dropped before grant: no transaction occurs. After grant, the latched request completes regardless of req.
- Reset mid-transaction: the next edge forces IDLE with all outputs at reset values. No ack is issued, and no ram_we occurs after the reset edge.
- Mode/width: the arbiter passes data through unmodified. Lane selection and zero-extension stay in the RAM.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds outputs stat_a_cnt[15:0], stat_b_cnt[15:0], stat_err_cnt[15:0].
  - Counters increment on the RESP cycle: per-port grant count, plus error count when err = 1.
  - Counters saturate at 16'hFFFF and clear on rst_n.
  - Adds input stat_clr (1 bit): synchronous clear; takes priority over an increment in the same cycle.
- MEM_ARB_STATS_EN undefined: the counters, stat_clr and the three outputs are absent. Core behaviour is identical in both builds.

Test Plan:
- A write word addr 0x010 data 0xDEADBEEF, then A read word 0x010 -> ram_we high exactly 1 cycle at t+1; a_ack at t+2 with a_err = 0; read returns a_rdata = 0xDEADBEEF.
- A and B request in the same cycle after reset, both held -> grant order A, B, A, B; each ack 3 cycles apart; b_ack never coincides with a_ack.
- B byte write 0x5A at 0x013, then B word read 0x010 -> b_rdata = 0x5AADBEEF.
- A word read at 0x012; A half write at 0x011; A mode 3 -> each gives a_ack with a_err = 1, a_rdata = 0, ram_we never asserted.
- rst_n low during ACCESS of a B write -> no b_ack, busy = 0 next cycle, ram_we low from the reset edge; a subsequent A request is serviced normally.
- With MEM_ARB_STATS_EN: 3 A grants, 2 B grants, 1 error -> stat_a_cnt = 3, stat_b_cnt = 2, stat_err_cnt = 1; stat_clr pulse -> all 0.
